// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V constants and fetch FSM state encoding
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_MASK      = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_HOLD = 2'd2,
    FS_DROP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - single-outstanding instruction fetch with redirect handling
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_VECTOR
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  fetch_state_e    state;
  fetch_state_e    state_d;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_d;
  logic            capture;
  logic            clear_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FS_REQ;
    end else begin
      state <= state_d;
    end
  end

  // Redirect outranks every other event; the response it collides with is thrown away.
  always_comb begin
    state_d = state;
    unique case (state)
      FS_REQ: begin
        if (redirect_valid) begin
          state_d = imem_req_ready ? FS_DROP : FS_REQ;
        end else if (imem_req_ready) begin
          state_d = FS_WAIT;
        end
      end
      FS_WAIT: begin
        if (imem_rsp_valid) begin
          state_d = redirect_valid ? FS_REQ : FS_HOLD;
        end else if (redirect_valid) begin
          state_d = FS_DROP;
        end
      end
      FS_HOLD: begin
        if (redirect_valid || instr_ready) begin
          state_d = FS_REQ;
        end
      end
      FS_DROP: begin
        if (imem_rsp_valid) begin
          state_d = FS_REQ;
        end
      end
      default: state_d = FS_REQ;
    endcase
  end

  always_comb begin
    imem_req_valid = rst && (state == FS_REQ);
    imem_addr      = pc;
    pc_d           = pc;
    capture        = 1'b0;
    clear_valid    = 1'b0;
    if (redirect_valid) begin
      pc_d        = redirect_pc & PC_MASK;
      clear_valid = 1'b1;
    end else if ((state == FS_WAIT) && imem_rsp_valid) begin
      pc_d    = pc + 32'd4;
      capture = 1'b1;
    end else if ((state == FS_HOLD) && instr_ready) begin
      clear_valid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC & PC_MASK;
      instr_valid <= 1'b0;
      instruction <= NOP_INSTR;
      instr_pc    <= '0;
    end else begin
      pc <= pc_d;
      if (capture) begin
        instruction <= imem_rsp_data;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
      end else if (clear_valid) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 imem_req_valid  output  1  fetch request to instruction memory.
REQ-005 imem_req_ready  input  1  memory accepts request this cycle.
REQ-006 imem_addr  output  32  word-aligned fetch address.
REQ-007 imem_rsp_valid  input  1  fetched word valid this cycle.
REQ-008 imem_rsp_data  input  32  fetched instruction word.
REQ-009 instr_valid  output  1  instruction offered to the decode stage.
REQ-010 instr_ready  input  1  decode stage accepts the instruction.
REQ-011 instruction  output  32  instruction word to decode.
REQ-012 instr_pc  output  32  address of the offered instruction.
REQ-013 redirect_valid  input  1  branch/jump redirect from a later stage.
REQ-014 redirect_pc  input  32  redirect target.

Function
REQ-015 The block SHALL hold at most one outstanding memory request.
REQ-016 FSM states SHALL be REQ, WAIT, HOLD, DROP.
REQ-017 REQ: imem_req_valid=1, imem_addr=pc; req_valid&&req_ready -> WAIT.
REQ-018 WAIT: imem_rsp_valid -> latch instruction=rsp_data, instr_pc=pc, instr_valid=1, pc<=pc+4, next HOLD.
REQ-019 HOLD: instr_valid=1; instr_ready -> instr_valid=0 next cycle, next REQ.
REQ-020 Response-to-instr_valid latency SHALL be 1 cycle; minimum throughput is one instruction per 3 cycles.
REQ-021 While instr_valid=1 and instr_ready=0, instruction and instr_pc SHALL remain stable.
REQ-022 imem_req_valid SHALL be 0 outside REQ; imem_addr SHALL equal pc at all times.
REQ-023 redirect_valid SHALL take priority over all other events in the same cycle.
REQ-024 Redirect in REQ without handshake, or in HOLD: pc<=redirect_pc, instr_valid<=0, next REQ.
REQ-025 Redirect in REQ with same-cycle req handshake: pc<=redirect_pc, next DROP.
REQ-026 Redirect in WAIT without rsp_valid: pc<=redirect_pc, next DROP; with rsp_valid: response discarded, pc<=redirect_pc, next REQ.
REQ-027 DROP: imem_rsp_valid discards the word, next REQ; redirect in DROP updates pc, remains DROP (or REQ if rsp_valid same cycle).
REQ-028 redirect_pc[1:0] SHALL be ignored; pc low two bits SHALL always be 0.
REQ-029 pc increment SHALL be modulo 2^32 (32'hFFFF_FFFC + 4 -> 32'h0000_0000).
REQ-030 imem_rsp_valid in REQ or HOLD SHALL be ignored with no state change.
REQ-031 Redirect in HOLD with same-cycle instr_ready SHALL count as consumed by decode; instruction is not re-offered.

Reset
REQ-032 While rst=0: state=REQ, pc=RESET_PC, instr_valid=0, instruction=32'h0000_0013 (NOP), instr_pc=0, imem_req_valid=0.
REQ-033 First cycle after rst release SHALL assert imem_req_valid with imem_addr=RESET_PC.
REQ-034 Reset assertion mid-transaction SHALL abandon any outstanding request; responses arriving after release while in REQ are ignored per REQ-030.

Structure
REQ-035 Shared package riscv_pkg SHALL hold XLEN=32, NOP encoding 32'h0000_0013, default reset vector, and the fetch FSM state enum.
REQ-036 Single module, no sub-modules; pc register, FSM and output register are local.

Verification
REQ-037 Reset release, req_ready=1, rsp one cycle later with 32'h0050_0093, instr_ready=1 -> instr_valid with instr_pc=0; next imem_addr=4.
REQ-038 instr_ready held 0 for 5 cycles in HOLD -> instruction/instr_pc stable, imem_req_valid=0 throughout.
REQ-039 Redirect to 32'h0000_0100 in WAIT, response arrives 2 cycles later -> response dropped, next request addr 32'h0000_0100, no instr_valid from dropped word.
REQ-040 Redirect to 32'h0000_0203 -> imem_addr=32'h0000_0200.
REQ-041 pc=32'hFFFF_FFFC fetch completes -> next imem_addr=32'h0000_0000.
REQ-042 rst asserted during WAIT, deasserted, stale rsp_valid in REQ -> ignored, imem_addr=RESET_PC, instr_valid=0.
